// File: rtl/instruction_line_responder.sv
// Direct-mapped instruction line cache that answers prefetch line requests,
// serving hits in one cycle and filling misses word-by-word from a 32-bit memory port.
module instruction_line_responder #(
    parameter int AddressBusWidth  = 32,
    parameter int InstructionWidth = 32,
    parameter int IndexBits        = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [AddressBusWidth-1:0]    PreFetchedAddress,
    input  logic                          PreFetchedRequest,
    output logic [4*InstructionWidth-1:0] PreFetchedInstructions,
    output logic                          PreFetchedWait,
    output logic [AddressBusWidth-1:0]    MemAddress,
    output logic                          MemRequest,
    input  logic [InstructionWidth-1:0]   MemData,
    input  logic                          MemWait,
    input  logic                          CacheFlush
);

    localparam int LineWidth = 4 * InstructionWidth;
    localparam int Lines     = 1 << IndexBits;
    localparam int TagBits   = AddressBusWidth - 4 - IndexBits;

    typedef enum logic [1:0] {
        Idle    = 2'd0,
        Fill    = 2'd1,
        Respond = 2'd2
    } state_t;

    state_t state;
    state_t nextState;

    logic [LineWidth-1:0] lineStore [Lines];
    logic [TagBits-1:0]   tagStore  [Lines];
    logic [Lines-1:0]     validBits;

    logic [3:0][InstructionWidth-1:0] fillWords;
    logic [1:0]                       wordCount;
    logic [TagBits-1:0]               fillTag;
    logic [IndexBits-1:0]             fillIdx;
    logic [AddressBusWidth-1:0]       memAddressReg;
    logic                             memRequestReg;

    logic [IndexBits-1:0] reqIdx;
    logic [TagBits-1:0]   reqTag;
    logic                 hit;
    logic                 unusedOffsetBits;

    assign reqIdx           = PreFetchedAddress[4+IndexBits-1:4];
    assign reqTag           = PreFetchedAddress[AddressBusWidth-1:4+IndexBits];
    assign hit              = validBits[reqIdx] && (tagStore[reqIdx] == reqTag);
    assign unusedOffsetBits = ^PreFetchedAddress[3:0];

    assign MemAddress = memAddressReg;
    assign MemRequest = memRequestReg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= Idle;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState              = state;
        PreFetchedWait         = 1'b0;
        PreFetchedInstructions = lineStore[reqIdx];
        case (state)
            Idle: begin
                PreFetchedWait = PreFetchedRequest && !hit;
                if (PreFetchedRequest && !hit) begin
                    nextState = Fill;
                end
            end
            Fill: begin
                PreFetchedWait         = 1'b1;
                PreFetchedInstructions = fillWords;
                if (!MemWait && wordCount == 2'd3) begin
                    nextState = Respond;
                end
            end
            Respond: begin
                PreFetchedInstructions = fillWords;
                nextState              = Idle;
            end
            default: begin
                nextState = Idle;
            end
        endcase
    end

    // Flush is applied before the Respond write so the freshly filled line survives a coinciding flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < Lines; i++) begin
                lineStore[i] <= '0;
                tagStore[i]  <= '0;
            end
            validBits     <= '0;
            fillWords     <= '0;
            wordCount     <= 2'd0;
            fillTag       <= '0;
            fillIdx       <= '0;
            memAddressReg <= '0;
            memRequestReg <= 1'b0;
        end else begin
            if (CacheFlush) begin
                validBits <= '0;
            end
            case (state)
                Idle: begin
                    if (PreFetchedRequest && !hit) begin
                        fillTag       <= reqTag;
                        fillIdx       <= reqIdx;
                        memAddressReg <= {PreFetchedAddress[AddressBusWidth-1:4], 4'b0000};
                        memRequestReg <= 1'b1;
                        wordCount     <= 2'd0;
                    end
                end
                Fill: begin
                    // Only the word-offset bits advance, keeping the burst inside one aligned line.
                    if (!MemWait) begin
                        fillWords[wordCount] <= MemData;
                        memAddressReg[3:2]   <= memAddressReg[3:2] + 2'd1;
                        wordCount            <= wordCount + 2'd1;
                        if (wordCount == 2'd3) begin
                            memRequestReg <= 1'b0;
                        end
                    end
                end
                Respond: begin
                    lineStore[fillIdx] <= fillWords;
                    tagStore[fillIdx]  <= fillTag;
                    validBits[fillIdx] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_line_responder.sv
// Bench for instruction_line_responder: directed request sequences checked every cycle
// against a line-level cache model and a synthetic memory image.
module tb_instruction_line_responder;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  PreFetchedAddress = '0;
    logic         PreFetchedRequest = 1'b0;
    logic [127:0] PreFetchedInstructions;
    logic         PreFetchedWait;
    logic [31:0]  MemAddress;
    logic         MemRequest;
    logic [31:0]  MemData = '0;
    logic         MemWait = 1'b0;
    logic         CacheFlush = 1'b0;

    instruction_line_responder #(
        .AddressBusWidth (32),
        .InstructionWidth(32),
        .IndexBits       (3)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .PreFetchedAddress     (PreFetchedAddress),
        .PreFetchedRequest     (PreFetchedRequest),
        .PreFetchedInstructions(PreFetchedInstructions),
        .PreFetchedWait        (PreFetchedWait),
        .MemAddress            (MemAddress),
        .MemRequest            (MemRequest),
        .MemData               (MemData),
        .MemWait               (MemWait),
        .CacheFlush            (CacheFlush)
    );

    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    logic         checkEn   = 1'b0;
    logic         expWait   = 1'b0;
    logic         expMemReq = 1'b0;
    logic [31:0]  expMemAddr = '0;
    logic         checkData = 1'b0;
    logic [127:0] expData   = '0;
    string        phase     = "idle";

    // Line-level model: which line address is resident at each index.
    logic [27:0] residentLine  [8];
    logic        residentValid [8];

    logic [127:0] captured;
    int           held;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (((a >> 4) - 32'h10) << 8) | (32'hA0 + 32'(a[3:2]));
    endfunction

    function automatic logic [127:0] lineOf(input logic [31:0] a);
        logic [3:0][31:0] w;
        for (int k = 0; k < 4; k++) begin
            w[k] = memWord({a[31:4], 4'b0000} + 32'(4 * k));
        end
        return w;
    endfunction

    function automatic bit modelHit(input logic [31:0] a);
        return residentValid[a[6:4]] && (residentLine[a[6:4]] == a[31:4]);
    endfunction

    function automatic void modelInvalidateAll();
        for (int i = 0; i < 8; i++) begin
            residentValid[i] = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    always @(negedge clock) begin
        if (checkEn) begin
            checkOutput({phase, " wait"}, 128'(PreFetchedWait), 128'(expWait));
            checkOutput({phase, " memreq"}, 128'(MemRequest), 128'(expMemReq));
            if (expMemReq) begin
                checkOutput({phase, " memaddr"}, 128'(MemAddress), 128'(expMemAddr));
            end
            if (checkData) begin
                checkOutput({phase, " line"}, PreFetchedInstructions, expData);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic expectIdle();
        expWait   = 1'b0;
        expMemReq = 1'b0;
        checkData = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        PreFetchedRequest = 1'b0;
        phase = "idle";
        expectIdle();
        for (int i = 0; i < n; i++) begin
            nextCycle();
        end
    endtask

    // Issues one line request and walks it through hit or miss, stalling before one word if asked.
    task automatic applyStimulus(input logic [31:0] addr, input int stallWord, input int stallCycles,
                                 input bit flushAtRespond, output int heldCycles,
                                 output logic [127:0] seenLine);
        logic [31:0] base;
        base = {addr[31:4], 4'b0000};
        heldCycles = 0;
        seenLine = '0;
        PreFetchedAddress = addr;
        PreFetchedRequest = 1'b1;
        MemWait = 1'b0;
        phase = $sformatf("req %h", addr);
        if (modelHit(addr)) begin
            expWait = 1'b0; expMemReq = 1'b0; checkData = 1'b1; expData = lineOf(base);
            #4; seenLine = PreFetchedInstructions;
            nextCycle(); heldCycles++;
        end else begin
            expWait = 1'b1; expMemReq = 1'b0; checkData = 1'b0;
            nextCycle(); heldCycles++;
            for (int k = 0; k < 4; k++) begin
                expWait = 1'b1; expMemReq = 1'b1; expMemAddr = base + 32'(4 * k);
                for (int s = 0; s < ((k == stallWord) ? stallCycles : 0); s++) begin
                    MemWait = 1'b1; MemData = 32'hDEADBEEF;
                    nextCycle(); heldCycles++;
                end
                MemWait = 1'b0; MemData = memWord(base + 32'(4 * k));
                nextCycle(); heldCycles++;
            end
            expWait = 1'b0; expMemReq = 1'b0; checkData = 1'b1; expData = lineOf(base);
            CacheFlush = flushAtRespond;
            #4; seenLine = PreFetchedInstructions;
            nextCycle(); heldCycles++;
            CacheFlush = 1'b0;
            if (flushAtRespond) begin
                modelInvalidateAll();
            end
            residentValid[addr[6:4]] = 1'b1;
            residentLine[addr[6:4]]  = addr[31:4];
        end
        PreFetchedRequest = 1'b0;
        phase = "idle";
        expectIdle();
    endtask

    initial begin
        modelInvalidateAll();
        for (int i = 0; i < 8; i++) begin
            residentLine[i] = '0;
        end

        // Reset values while reset is held low
        #1 reset = 1'b0;
        #1;
        checkOutput("reset wait", 128'(PreFetchedWait), 128'(1'b0));
        checkOutput("reset memreq", 128'(MemRequest), 128'(1'b0));
        checkOutput("reset memaddr", 128'(MemAddress), 128'(32'h0));
        checkOutput("reset line", PreFetchedInstructions, 128'h0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
        expectIdle();
        checkEn = 1'b1;
        idleCycles(2);

        // Cold miss with literal line and latency
        applyStimulus(32'h0000_0100, -1, 0, 1'b0, held, captured);
        checkOutput("cold line literal", captured, 128'h000000A3_000000A2_000000A1_000000A0);
        checkOutput("cold latency", 128'(held), 128'(6));
        idleCycles(1);

        // Hit after fill
        applyStimulus(32'h0000_0108, -1, 0, 1'b0, held, captured);
        checkOutput("hit latency", 128'(held), 128'(1));
        checkOutput("hit line literal", captured, 128'h000000A3_000000A2_000000A1_000000A0);
        idleCycles(1);

        // Memory stall before word 2
        applyStimulus(32'h0000_0200, 2, 3, 1'b0, held, captured);
        checkOutput("stall line literal", captured, 128'h000010A3_000010A2_000010A1_000010A0);
        checkOutput("stall latency", 128'(held), 128'(9));
        idleCycles(1);

        // Index conflict: 0x180 evicts 0x100 at index 0
        applyStimulus(32'h0000_0180, -1, 0, 1'b0, held, captured);
        idleCycles(1);
        applyStimulus(32'h0000_0100, -1, 0, 1'b0, held, captured);
        checkOutput("conflict refill latency", 128'(held), 128'(6));
        idleCycles(1);

        // Flush in Idle forces a refill
        applyStimulus(32'h0000_0300, -1, 0, 1'b0, held, captured);
        idleCycles(1);
        CacheFlush = 1'b1;
        idleCycles(1);
        CacheFlush = 1'b0;
        modelInvalidateAll();
        idleCycles(1);
        applyStimulus(32'h0000_0300, -1, 0, 1'b0, held, captured);
        checkOutput("flush refill latency", 128'(held), 128'(6));
        idleCycles(1);

        // Flush coinciding with Respond keeps only the line being written
        applyStimulus(32'h0000_0410, -1, 0, 1'b0, held, captured);
        idleCycles(1);
        applyStimulus(32'h0000_0180, -1, 0, 1'b1, held, captured);
        idleCycles(1);
        applyStimulus(32'h0000_0180, -1, 0, 1'b0, held, captured);
        checkOutput("flush-at-respond survivor", 128'(held), 128'(1));
        idleCycles(1);
        applyStimulus(32'h0000_0410, -1, 0, 1'b0, held, captured);
        checkOutput("flush-at-respond victim", 128'(held), 128'(6));
        idleCycles(1);

        // Reset after two words of a miss
        PreFetchedAddress = 32'h0000_0100;
        PreFetchedRequest = 1'b1;
        phase = "rst-fill";
        expWait = 1'b1; expMemReq = 1'b0; checkData = 1'b0;
        nextCycle();
        for (int k = 0; k < 2; k++) begin
            expMemReq = 1'b1; expMemAddr = 32'h100 + 32'(4 * k);
            MemWait = 1'b0; MemData = memWord(32'h100 + 32'(4 * k));
            nextCycle();
        end
        reset = 1'b0;
        expMemReq = 1'b0;
        #1;
        checkOutput("reset mid-fill memreq", 128'(MemRequest), 128'(1'b0));
        modelInvalidateAll();
        nextCycle();
        PreFetchedRequest = 1'b0;
        expectIdle();
        nextCycle();
        reset = 1'b1;
        idleCycles(1);
        applyStimulus(32'h0000_0100, -1, 0, 1'b0, held, captured);
        checkOutput("post-reset refill latency", 128'(held), 128'(6));
        checkOutput("post-reset line literal", captured, 128'h000000A3_000000A2_000000A1_000000A0);
        idleCycles(2);

        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
